// File: rtl/burst_worker_fsm.sv
// ---------------------------------------------------------------------------
// burst_worker_fsm
//
// Worker FSM driven by the master sequencer's start/busy/done handshake.
// One accepted start emits BURST_LEN incrementing data words (starting at
// seed) on a valid/ready interface. A sink that stalls for STALL_LIMIT
// consecutive cycles aborts the burst with err. Completion and abort are
// reported as level flags that persist in IDLE until the next accepted start.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, seed           start request (sampled in IDLE) and first data word
//   tx_valid/ready/data   beat handshake towards the sink
//   tx_last               marks the final beat of the burst
//   state                 IDLE=00, RUN=01, FINISH=10, ERROR=11
//   busy, done, err       status back to the master
//   beats_sent            beats accepted in the current/last burst
// ---------------------------------------------------------------------------
module burst_worker_fsm #(
    parameter int DATA_W      = 8,
    parameter int BURST_LEN   = 16,
    parameter int STALL_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       beats_sent
);

    localparam int          SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [16:0] LEN       = 17'(BURST_LEN);
    localparam logic [16:0] LAST_IDX  = 17'(BURST_LEN - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10,
        S_ERROR  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_last_q, tx_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       beats_q, beats_d;
    logic [SW-1:0]     stall_q, stall_d;

    logic              xfer;
    logic [16:0]       beats_inc;
    logic [SW-1:0]     stall_inc;

    assign xfer      = tx_valid_q & tx_ready;
    assign beats_inc = {1'b0, beats_q} + 17'd1;
    assign stall_inc = stall_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        beats_d    = beats_q;
        stall_d    = stall_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    beats_d    = '0;
                    stall_d    = '0;
                    tx_data_d  = seed;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (LEN == 17'd1);
                end
            end
            S_RUN: begin
                if (xfer) begin
                    // A transfer always wins over the stall limit on the same edge.
                    beats_d   = beats_inc[15:0];
                    tx_data_d = tx_data_q + 1'b1;
                    stall_d   = '0;
                    if (beats_inc == LEN) begin
                        state_d    = S_FINISH;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        tx_last_d = (beats_inc == LAST_IDX);
                    end
                end else begin
                    // tx_valid is always high in RUN, so no transfer means a stall.
                    stall_d = stall_inc;
                    if (stall_inc == STALL_MAX) begin
                        state_d    = S_ERROR;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        stall_d    = '0;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
                tx_last_d  = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                err_d      = 1'b0;
                beats_d    = '0;
                stall_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            beats_q    <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            beats_q    <= beats_d;
            stall_q    <= stall_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_last    = tx_last_q;
    assign state      = state_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign beats_sent = beats_q;

endmodule

// File: tb/tb_burst_worker_fsm.sv
// ---------------------------------------------------------------------------
// tb_burst_worker_fsm
//
// Directed bench: a table of per-cycle {inputs, expected outputs} records for
// a BURST_LEN=4 / STALL_LIMIT=5 instance, plus hand-written sequences for
// async reset and a second BURST_LEN=1 instance.
// ---------------------------------------------------------------------------
module tb_burst_worker_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // BURST_LEN=4 instance
    logic        start = 1'b0, tx_ready = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        tx_valid, tx_last, busy, done, err;
    logic [7:0]  tx_data;
    logic [1:0]  state;
    logic [15:0] beats_sent;

    // BURST_LEN=1 instance
    logic        start1 = 1'b0, tx_ready1 = 1'b0;
    logic [7:0]  seed1 = 8'h00;
    logic        tx_valid1, tx_last1, busy1, done1, err1;
    logic [7:0]  tx_data1;
    logic [1:0]  state1;
    logic [15:0] beats_sent1;

    burst_worker_fsm #(.DATA_W(8), .BURST_LEN(4), .STALL_LIMIT(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .state(state),
        .busy(busy), .done(done), .err(err), .beats_sent(beats_sent)
    );

    burst_worker_fsm #(.DATA_W(8), .BURST_LEN(1), .STALL_LIMIT(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1), .tx_ready(tx_ready1),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_last(tx_last1), .state(state1),
        .busy(busy1), .done(done1), .err(err1), .beats_sent(beats_sent1)
    );

    typedef struct {
        logic        s;
        logic [7:0]  seed;
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [1:0]  st;
        logic        b, dn, e;
        logic [15:0] bs;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Data is only meaningful while valid is high, so it is zeroed otherwise.
    function automatic logic [30:0] pk(logic v, logic [7:0] d, logic l, logic [1:0] st,
                                       logic b, logic dn, logic e, logic [15:0] bs);
        return {v, (v ? d : 8'h00), l, st, b, dn, e, bs};
    endfunction

    task automatic chk(string nm, logic [30:0] act, logic [30:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got v/d/l/st/b/dn/e/bs=%h want %h", nm, act, exp);
        end
    endtask

    task automatic add(logic s, logic [7:0] sd, logic r, logic v, logic [7:0] d, logic l,
                       logic [1:0] st, logic b, logic dn, logic e, logic [15:0] bs);
        vec_t x;
        x.s = s; x.seed = sd; x.r = r; x.v = v; x.d = d; x.l = l;
        x.st = st; x.b = b; x.dn = dn; x.e = e; x.bs = bs;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] act0();
        return pk(tx_valid, tx_data, tx_last, state, busy, done, err, beats_sent);
    endfunction

    function automatic logic [30:0] act1();
        return pk(tx_valid1, tx_data1, tx_last1, state1, busy1, done1, err1, beats_sent1);
    endfunction

    initial begin
        // T1: seed 10, sink always ready
        add(1,8'h10,1, 1,8'h10,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'h11,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h12,0,2'd1,1,0,0,2);
        add(0,8'h00,1, 1,8'h13,1,2'd1,1,0,0,3);
        add(0,8'h00,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);
        // T2: data wrap FE,FF,00,01
        add(1,8'hFE,1, 1,8'hFE,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'hFF,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h00,0,2'd1,1,0,0,2);
        add(0,8'h00,1, 1,8'h01,1,2'd1,1,0,0,3);
        add(0,8'h00,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);
        // T3: ready pattern 1,0,0,1,1,0,0,1 -- data held during stalls
        add(1,8'h40,0, 1,8'h40,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'h41,0,2'd1,1,0,0,1);
        add(0,8'h00,0, 1,8'h41,0,2'd1,1,0,0,1);
        add(0,8'h00,0, 1,8'h41,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h42,0,2'd1,1,0,0,2);
        add(0,8'h00,1, 1,8'h43,1,2'd1,1,0,0,3);
        add(0,8'h00,0, 1,8'h43,1,2'd1,1,0,0,3);
        add(0,8'h00,0, 1,8'h43,1,2'd1,1,0,0,3);
        add(0,8'h00,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);
        // T4: start held high -- one burst per IDLE visit, done cleared on accept
        add(1,8'h80,1, 1,8'h80,0,2'd1,1,0,0,0);
        add(1,8'h80,1, 1,8'h81,0,2'd1,1,0,0,1);
        add(1,8'h80,1, 1,8'h82,0,2'd1,1,0,0,2);
        add(1,8'h80,1, 1,8'h83,1,2'd1,1,0,0,3);
        add(1,8'h80,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(1,8'h80,1, 0,8'h00,0,2'd0,0,1,0,4);
        add(1,8'h80,1, 1,8'h80,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'h81,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h82,0,2'd1,1,0,0,2);
        add(0,8'h00,1, 1,8'h83,1,2'd1,1,0,0,3);
        add(0,8'h00,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);
        // T5: stall abort after 2 beats, 5th stalled edge enters ERROR
        add(1,8'h20,1, 1,8'h20,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'h21,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h22,0,2'd1,1,0,0,2);
        add(0,8'h00,0, 1,8'h22,0,2'd1,1,0,0,2);
        add(0,8'h00,0, 1,8'h22,0,2'd1,1,0,0,2);
        add(0,8'h00,0, 1,8'h22,0,2'd1,1,0,0,2);
        add(0,8'h00,0, 1,8'h22,0,2'd1,1,0,0,2);
        add(0,8'h00,0, 0,8'h00,0,2'd3,0,1,1,2);
        add(0,8'h00,0, 0,8'h00,0,2'd0,0,1,1,2);
        add(0,8'h00,0, 0,8'h00,0,2'd0,0,1,1,2);
        // new start clears done/err at the accepting edge
        add(1,8'h30,0, 1,8'h30,0,2'd1,1,0,0,0);
        add(0,8'h00,1, 1,8'h31,0,2'd1,1,0,0,1);
        add(0,8'h00,1, 1,8'h32,0,2'd1,1,0,0,2);
        add(0,8'h00,1, 1,8'h33,1,2'd1,1,0,0,3);
        add(0,8'h00,1, 0,8'h00,0,2'd2,0,1,0,4);
        add(0,8'h00,1, 0,8'h00,0,2'd0,0,1,0,4);

        // Reset state (held in reset across a few edges)
        rst_n = 1'b0;
        #22;
        chk("reset_state", act0(), pk(0,8'h00,0,2'd0,0,0,0,16'd0));
        chk("reset_data", {23'd0, tx_data}, 31'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            start    = vecs[i].s;
            seed     = vecs[i].seed;
            tx_ready = vecs[i].r;
            step();
            chk($sformatf("vec%0d", i), act0(),
                pk(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].st,
                   vecs[i].b, vecs[i].dn, vecs[i].e, vecs[i].bs));
        end

        // Async reset mid-burst (at beat 2 of 4)
        start = 1'b1; seed = 8'h50; tx_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_reset", act0(), pk(1,8'h52,0,2'd1,1,0,0,16'd2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", act0(), pk(0,8'h00,0,2'd0,0,0,0,16'd0));
        chk("async_reset_data", {23'd0, tx_data}, 31'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", act0(), pk(0,8'h00,0,2'd0,0,0,0,16'd0));
        start = 1'b1; seed = 8'h60; tx_ready = 1'b1;
        step();
        chk("post_reset_start", act0(), pk(1,8'h60,0,2'd1,1,0,0,16'd0));
        start = 1'b0;
        step();
        step();
        step();
        chk("post_reset_last", act0(), pk(1,8'h63,1,2'd1,1,0,0,16'd3));
        step();
        chk("post_reset_finish", act0(), pk(0,8'h00,0,2'd2,0,1,0,16'd4));

        // BURST_LEN=1: valid and last on the same single beat
        start1 = 1'b1; seed1 = 8'hA5; tx_ready1 = 1'b0;
        step();
        chk("len1_start", act1(), pk(1,8'hA5,1,2'd1,1,0,0,16'd0));
        start1 = 1'b0; tx_ready1 = 1'b1;
        step();
        chk("len1_finish", act1(), pk(0,8'h00,0,2'd2,0,1,0,16'd1));
        step();
        chk("len1_idle", act1(), pk(0,8'h00,0,2'd0,0,1,0,16'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
